fft_dif_sched: RTL

In-place radix-2 decimation-in-frequency FFT scheduler that drives one shared butterfly unit (sum on the upper leg, twiddle multiply on the difference leg) against a dual-port sample RAM. On `start` it runs all log2(N) stages. Each cycle in an issue phase it emits one read address pair plus a twiddle ROM index. It writes results back to the same address pair a fixed pipeline latency later and drains the pipeline between stages so no read overtakes a pending write. Output data is in bit-reversed order; unscrambling is done downstream.

---
 rtl/fft_dif_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fft_dif_sched.sv
// In-place radix-2 DIF FFT scheduler: issues butterfly read pairs and twiddle indices
// stage by stage, and replays each pair as a write PIPE_LAT cycles later.
module fft_dif_sched #(
   parameter int N_LOG2   = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [N_LOG2-1:0] stage,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr_a,
   output logic [N_LOG2-1:0] rd_addr_b,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              wr_en,
   output logic [N_LOG2-1:0] wr_addr_a,
   output logic [N_LOG2-1:0] wr_addr_b
);

   localparam int W  = N_LOG2;
   localparam int HW = N_LOG2 - 1;
   localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [HW-1:0] J_LAST = {HW{1'b1}};
   localparam logic [W-1:0]  S_LAST = W'(N_LOG2 - 1);
   localparam logic [CW-1:0] C_LAST = CW'(PIPE_LAT - 1);
   localparam logic [W-1:0]  HALF   = {1'b1, {HW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_r, state_nx_s;
   logic [W-1:0]    s_r, s_nx_s;
   logic [HW-1:0]   j_r, j_nx_s;
   logic [CW-1:0]   cnt_r, cnt_nx_s;

   logic [W-1:0]    j_ext_s, span_s, mask_s, k_s, a_s, b_s;
   logic            busy_s, done_s, rd_s;
   logic [W-1:0]    rd_a_s, rd_b_s;
   logic [HW-1:0]   tw_s;

   logic            pipe_v_r [PIPE_LAT];
   logic [W-1:0]    pipe_a_r [PIPE_LAT];
   logic [W-1:0]    pipe_b_r [PIPE_LAT];

   // State, stage, butterfly and drain counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         s_r     <= {W{1'b0}};
         j_r     <= {HW{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nx_s;
         s_r     <= s_nx_s;
         j_r     <= j_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_nx_s = state_r;
      s_nx_s     = s_r;
      j_nx_s     = j_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nx_s = S_ISSUE;
               s_nx_s     = {W{1'b0}};
               j_nx_s     = {HW{1'b0}};
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (j_r == J_LAST) begin
               state_nx_s = S_DRAIN;
               cnt_nx_s   = {CW{1'b0}};
            end else begin
               j_nx_s = j_r + HW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_r == C_LAST) begin
               if (s_r == S_LAST) begin
                  state_nx_s = S_DONE;
               end else begin
                  state_nx_s = S_ISSUE;
                  s_nx_s     = s_r + W'(1);
                  j_nx_s     = {HW{1'b0}};
               end
            end else begin
               cnt_nx_s = cnt_r + CW'(1);
            end
         end
         S_DONE:  state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up with it
   always_comb begin
      j_ext_s = {1'b0, j_nx_s};
      span_s  = HALF >> s_nx_s;
      mask_s  = span_s - W'(1);
      k_s     = j_ext_s & mask_s;
      // group base 2*g*span is the group bits of j moved up one position
      a_s     = ((j_ext_s & ~mask_s) << 1) | k_s;
      b_s     = a_s | span_s;
      busy_s  = (state_nx_s == S_ISSUE) || (state_nx_s == S_DRAIN);
      done_s  = (state_nx_s == S_DONE);
      rd_s    = (state_nx_s == S_ISSUE);
      if (rd_s) begin
         rd_a_s = a_s;
         rd_b_s = b_s;
         tw_s   = HW'(k_s << s_nx_s);
      end else begin
         rd_a_s = {W{1'b0}};
         rd_b_s = {W{1'b0}};
         tw_s   = {HW{1'b0}};
      end
   end

   // Registered control and read-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         stage     <= {W{1'b0}};
         rd_en     <= 1'b0;
         rd_addr_a <= {W{1'b0}};
         rd_addr_b <= {W{1'b0}};
         tw_addr   <= {HW{1'b0}};
      end else begin
         busy      <= busy_s;
         done      <= done_s;
         stage     <= s_nx_s;
         rd_en     <= rd_s;
         rd_addr_a <= rd_a_s;
         rd_addr_b <= rd_b_s;
         tw_addr   <= tw_s;
      end
   end

   // Write-back delay line; shifts in every state so the final stage drains out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_v_r[i] <= 1'b0;
            pipe_a_r[i] <= {W{1'b0}};
            pipe_b_r[i] <= {W{1'b0}};
         end
      end else begin
         pipe_v_r[0] <= rd_en;
         pipe_a_r[0] <= rd_addr_a;
         pipe_b_r[0] <= rd_addr_b;
         for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_v_r[i] <= pipe_v_r[i-1];
            pipe_a_r[i] <= pipe_a_r[i-1];
            pipe_b_r[i] <= pipe_b_r[i-1];
         end
      end
   end

   assign wr_en     = pipe_v_r[PIPE_LAT-1];
   assign wr_addr_a = pipe_a_r[PIPE_LAT-1];
   assign wr_addr_b = pipe_b_r[PIPE_LAT-1];

endmodule
